// File: rtl/sr_reg_dump_master.sv
//------------------------------------------------------------------------------
// sr_reg_dump_master
//
// Initiator side of the CPU debug register port. On a start request (or when
// the optional auto-restart timer expires) it walks debug addresses
// FIRST_REG..LAST_REG. Each address is driven onto regAddr, and regData is
// captured SETTLE edges later. The result is streamed out as an
// {addr, data, last} record over a valid/ready interface. Address 0 reads
// back the CPU's PC. That value is forwarded untouched like any other.
//
// Every record is a snapshot taken at its own capture edge. The CPU keeps
// running during a dump, so records are not mutually consistent.
//
// Parameters
//   FIRST_REG    first debug address dumped (0..31)
//   LAST_REG     last debug address dumped (FIRST_REG..31)
//   SETTLE       edges regAddr is held before regData is captured (>= 1)
//   AUTO_PERIOD  idle edges after a dump before an automatic restart; 0 = off
//
// Ports
//   clk        in   1   clock
//   rst        in   1   asynchronous reset, active-low
//   start      in   1   one-cycle dump request, ignored while busy
//   abort      in   1   synchronous cancel; wins over start and handshake
//   regAddr    out  5   debug register address driven to the CPU
//   regData    in   32  debug register data (combinational from regAddr)
//   out_valid  out  1   record available
//   out_ready  in   1   sink accepts record
//   out_addr   out  5   register address of the record
//   out_data   out  32  captured register value
//   out_last   out  1   record is the LAST_REG entry
//   busy       out  1   dump in progress
//   done       out  1   one-cycle pulse after the last record is accepted
//------------------------------------------------------------------------------
module sr_reg_dump_master #(
    parameter int FIRST_REG   = 0,
    parameter int LAST_REG    = 31,
    parameter int SETTLE      = 1,
    parameter int AUTO_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    // Counter widths sized to hold their reload values; never below one bit.
    localparam int WCNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int TMR_W  = (AUTO_PERIOD < 2) ? 1 : $clog2(AUTO_PERIOD + 1);

    localparam logic [4:0]        FIRST_V  = 5'(FIRST_REG);
    localparam logic [4:0]        LAST_V   = 5'(LAST_REG);
    localparam logic [WCNT_W-1:0] SETTLE_V = WCNT_W'(SETTLE);
    localparam logic [TMR_W-1:0]  AUTO_V   = TMR_W'(AUTO_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no dump running; auto timer may be counting
        S_WAIT = 2'd1,   // regAddr driven, waiting for regData to settle
        S_SEND = 2'd2    // record presented, waiting for the sink
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;    // settle edges remaining before capture
    logic [TMR_W-1:0]  timer;   // idle edges remaining before auto-restart

    // The timer only ever holds a non-zero value when AUTO_PERIOD > 0, so a
    // disabled auto-restart can never fire.
    logic auto_fire;
    assign auto_fire = (state == S_IDLE) && (timer == TMR_W'(1));

    // NOTE: every register below is state, so all updates are non-blocking;
    // blocking assignments here would make reads of a register see its new
    // value within the same edge and break the cycle-level timing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            timer     <= '0;
            regAddr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done is a pulse: it only survives the edge that sets it.
            done <= 1'b0;

            if (abort) begin
                // Cancel from any state. The record in flight is dropped, no
                // done pulse is produced and auto-restart is not re-armed.
                state     <= S_IDLE;
                wcnt      <= '0;
                timer     <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        // A manual start and a timer expiry on the same
                        // edge collapse into a single dump.
                        if (start || auto_fire) begin
                            regAddr <= FIRST_V;
                            wcnt    <= SETTLE_V;
                            timer   <= '0;
                            busy    <= 1'b1;
                            state   <= S_WAIT;
                        end else if (timer != '0) begin
                            timer <= timer - TMR_W'(1);
                        end
                    end

                    S_WAIT: begin
                        wcnt <= wcnt - WCNT_W'(1);
                        // Capture lands exactly SETTLE edges after regAddr
                        // was loaded.
                        if (wcnt == WCNT_W'(1)) begin
                            out_data  <= regData;
                            out_addr  <= regAddr;
                            out_last  <= (regAddr == LAST_V);
                            out_valid <= 1'b1;
                            state     <= S_SEND;
                        end
                    end

                    S_SEND: begin
                        // Record and regAddr stay frozen until accepted.
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                            if (out_last) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                timer <= AUTO_V;
                            end else begin
                                // LAST_REG <= 31 keeps this from wrapping.
                                regAddr <= regAddr + 5'd1;
                                wcnt    <= SETTLE_V;
                                state   <= S_WAIT;
                            end
                        end
                    end

                    default: begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
